// File: rtl/nios32_button_poller.sv
// Avalon-MM read master that periodically polls a 4-bit button PIO at address 0,
// debounces the whole sample vector and reports press/release pulses, a sticky irq and a press count.
module nios32_button_poller #(
    parameter int POLL_INTERVAL    = 1000,
    parameter int READ_LATENCY     = 1,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter bit ACTIVE_LOW       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic [3:0]  btn_state,
    output logic [3:0]  btn_press,
    output logic [3:0]  btn_release,
    output logic        irq,
    input  logic        irq_clear,
    output logic [15:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        EVAL
    } state_t;

    localparam int IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [IW-1:0] INT_LAST  = IW'(POLL_INTERVAL - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LATENCY - 1);
    localparam logic [3:0]    DEB_TH    = 4'(DEBOUNCE_SAMPLES);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   int_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [3:0]      sample;
    logic [3:0]      candidate;
    logic [3:0]      match_cnt;
    logic [3:0]      cnt_new;
    logic            accept;
    logic            capture;
    logic [3:0]      new_press;
    logic [3:0]      new_release;
    logic [2:0]      press_add;
    logic            unused_readdata;

    assign unused_readdata = ^avm_readdata[31:4];

    assign avm_address = 2'b00;
    assign avm_read    = (state == READ);

    // WAIT covers every cycle up to and including the one in which readdata is valid.
    assign capture = (state == WAIT) && (wait_cnt == WAIT_LAST);

    // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_cnt <= '0;
        end else if (!enable || int_cnt == INT_LAST) begin
            int_cnt <= '0;
        end else begin
            int_cnt <= int_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so no path leaves state_next unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (enable && int_cnt == INT_LAST) state_next = READ;
            READ: state_next = WAIT;
            WAIT: if (wait_cnt == WAIT_LAST) state_next = EVAL;
            EVAL: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            sample   <= '0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (capture) begin
                sample <= avm_readdata[3:0] ^ {4{ACTIVE_LOW}};
            end
        end
    end

    // Debounce acts on the whole vector: any differing bit restarts the match run.
    always_comb begin
        cnt_new     = 4'd1;
        accept      = 1'b0;
        new_press   = '0;
        new_release = '0;
        if (sample == candidate) begin
            cnt_new = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
        end
        if (state == EVAL && cnt_new >= DEB_TH && sample != btn_state) begin
            accept      = 1'b1;
            new_press   = sample & ~btn_state;
            new_release = ~sample & btn_state;
        end
        press_add = 3'(new_press[0]) + 3'(new_press[1]) + 3'(new_press[2]) + 3'(new_press[3]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            candidate   <= '0;
            match_cnt   <= '0;
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            press_count <= '0;
            irq         <= 1'b0;
        end else begin
            btn_press   <= new_press;
            btn_release <= new_release;
            if (state == EVAL) begin
                candidate <= sample;
                match_cnt <= cnt_new;
            end
            if (accept) begin
                btn_state   <= sample;
                press_count <= press_count + 16'(press_add);
            end
            // A press pulse outranks a coincident clear.
            irq <= (|btn_press) | (irq & ~irq_clear);
        end
    end

endmodule

// File: tb/tb_nios32_button_poller.sv
// Bench for nios32_button_poller: two instances (read latency 1 and 3) share buttons and controls,
// each behind a registered PIO model that returns junk outside its valid-data cycle.
module tb_nios32_button_poller;

    localparam int PI = 8;

    typedef struct packed {
        logic [3:0]  raw;
        logic [3:0]  state;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [15:0] cnt_a;
        logic [15:0] cnt_b;
        logic        irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        irq_clear;
    logic [3:0]  in_port;
    logic [31:0] junk;

    logic [1:0]  avm_address_a, avm_address_b;
    logic        avm_read_a, avm_read_b;
    logic [31:0] avm_readdata_a, avm_readdata_b;
    logic [3:0]  btn_state_a, btn_state_b;
    logic [3:0]  btn_press_a, btn_press_b;
    logic [3:0]  btn_release_a, btn_release_b;
    logic        irq_a, irq_b;
    logic [15:0] press_count_a, press_count_b;

    logic        pipe_a;
    logic [2:0]  pipe_b;

    int vectors = 0;
    int fails   = 0;

    vec_t tbl [22];
    vec_t sb_a [$];
    vec_t sb_b [$];

    always #5 clk = ~clk;

    nios32_button_poller #(.POLL_INTERVAL(PI), .READ_LATENCY(1), .DEBOUNCE_SAMPLES(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address_a), .avm_read(avm_read_a), .avm_readdata(avm_readdata_a),
        .btn_state(btn_state_a), .btn_press(btn_press_a), .btn_release(btn_release_a),
        .irq(irq_a), .irq_clear(irq_clear), .press_count(press_count_a)
    );

    nios32_button_poller #(.POLL_INTERVAL(PI), .READ_LATENCY(3), .DEBOUNCE_SAMPLES(4), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address_b), .avm_read(avm_read_b), .avm_readdata(avm_readdata_b),
        .btn_state(btn_state_b), .btn_press(btn_press_b), .btn_release(btn_release_b),
        .irq(irq_b), .irq_clear(irq_clear), .press_count(press_count_b)
    );

    // PIO models: data is valid only READ_LATENCY cycles after the strobe.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_a <= 1'b0;
            pipe_b <= '0;
        end else begin
            pipe_a <= avm_read_a;
            pipe_b <= {pipe_b[1:0], avm_read_b};
        end
    end

    always @(posedge clk) junk <= $urandom;

    assign avm_readdata_a = pipe_a    ? {junk[31:4], in_port} : junk;
    assign avm_readdata_b = pipe_b[2] ? {junk[31:4], in_port} : junk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_read(output int n);
        n = 0;
        while (avm_read_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            vectors++;
            fails++;
            $display("FAIL read_timeout: no avm_read within 40 cycles (t=%0t)", $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] raw, input logic [3:0] st, input logic [3:0] pr,
                                input logic [3:0] rl, input logic [15:0] cnt, input logic irq);
        vec_t v;
        v = '{raw: raw, state: st, press: pr, rel: rl, cnt_a: cnt, cnt_b: cnt, irq: irq};
        return v;
    endfunction

    // One poll: drive, wait for the strobe (T), check A at T+3 and B at T+5; returns at T+7.
    task automatic poll(input vec_t v, input bit drop_en);
        vec_t ea, eb;
        int   n;
        in_port = v.raw;
        sb_a.push_back(v);
        sb_b.push_back(v);
        wait_read(n);
        check("read_sync_b", avm_read_b, 1);
        check("address_a", avm_address_a, 0);
        if (drop_en) enable = 1'b0;
        @(negedge clk);
        check("read_one_cycle_a", avm_read_a, 0);
        @(negedge clk);
        check("press_early_a", btn_press_a, 0);
        @(negedge clk);
        ea = sb_a.pop_front();
        check("state_a", btn_state_a, ea.state);
        check("press_a", btn_press_a, ea.press);
        check("release_a", btn_release_a, ea.rel);
        check("count_a", press_count_a, ea.cnt_a);
        @(negedge clk);
        check("press_one_cycle_a", btn_press_a, 0);
        @(negedge clk);
        eb = sb_b.pop_front();
        check("state_b", btn_state_b, eb.state);
        check("press_b", btn_press_b, eb.press);
        check("release_b", btn_release_b, eb.rel);
        check("count_b", press_count_b, eb.cnt_b);
        check("irq_a", irq_a, ea.irq);
        @(negedge clk);
        check("press_one_cycle_b", btn_press_b, 0);
        @(negedge clk);
        check("irq_b", irq_b, eb.irq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   rd_seen;
        vec_t v;

        tbl[0]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[1]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[2]  = mk(4'hE, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[3]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[4]  = mk(4'hE, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[5]  = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[6]  = mk(4'hE, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[7]  = mk(4'hE, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[8]  = mk(4'hE, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0);
        tbl[9]  = mk(4'hE, 4'h1, 4'h1, 4'h0, 16'd1, 1'b1);
        tbl[10] = mk(4'hE, 4'h1, 4'h0, 4'h0, 16'd1, 1'b1);
        tbl[11] = mk(4'hC, 4'h1, 4'h0, 4'h0, 16'd1, 1'b1);
        tbl[12] = mk(4'hC, 4'h1, 4'h0, 4'h0, 16'd1, 1'b1);
        tbl[13] = mk(4'hC, 4'h1, 4'h0, 4'h0, 16'd1, 1'b1);
        tbl[14] = mk(4'hC, 4'h3, 4'h2, 4'h0, 16'd2, 1'b1);
        tbl[15] = mk(4'hD, 4'h3, 4'h0, 4'h0, 16'd2, 1'b1);
        tbl[16] = mk(4'hD, 4'h3, 4'h0, 4'h0, 16'd2, 1'b1);
        tbl[17] = mk(4'hD, 4'h3, 4'h0, 4'h0, 16'd2, 1'b1);
        tbl[18] = mk(4'hD, 4'h2, 4'h0, 4'h1, 16'd2, 1'b1);
        tbl[19] = mk(4'hC, 4'h2, 4'h0, 4'h0, 16'd2, 1'b1);
        tbl[20] = mk(4'hC, 4'h2, 4'h0, 4'h0, 16'd2, 1'b1);
        tbl[21] = mk(4'hC, 4'h2, 4'h0, 4'h0, 16'd2, 1'b1);

        reset_n   = 1'b0;
        enable    = 1'b1;
        irq_clear = 1'b0;
        in_port   = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_read_a", avm_read_a, 0);
        check("rst_address_b", avm_address_b, 0);
        check("rst_state_a", btn_state_a, 0);
        check("rst_irq_a", irq_a, 0);
        check("rst_count_b", press_count_b, 0);

        // First strobe POLL_INTERVAL cycles after reset release, then one every POLL_INTERVAL.
        reset_n = 1'b1;
        wait_read(n);
        check("first_read_delay", n, PI);
        check("first_read_b", avm_read_b, 1);
        @(negedge clk);
        n = 1;
        while (avm_read_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("read_interval", n, PI);

        for (int i = 0; i < 22; i++) begin
            poll(tbl[i], 1'b0);
        end

        // New press coinciding with irq_clear: the set wins; a clear alone drops irq.
        in_port = 4'hC;
        wait_read(n);
        repeat (3) @(negedge clk);
        check("irqseq_press_a", btn_press_a, 4'h1);
        check("irqseq_count_a", press_count_a, 3);
        irq_clear = 1'b1;
        @(negedge clk);
        check("irq_set_wins_a", irq_a, 1);
        check("irq_cleared_b", irq_b, 0);
        @(negedge clk);
        check("irqseq_press_b", btn_press_b, 4'h1);
        @(negedge clk);
        check("irq_cleared_a", irq_a, 0);
        check("irq_set_wins_b", irq_b, 1);
        irq_clear = 1'b0;
        @(negedge clk);
        check("irq_held_b", irq_b, 1);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("irq_clear_alone_b", irq_b, 0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            v = mk(4'hF, (i == 3) ? 4'h0 : 4'h3, 4'h0, (i == 3) ? 4'h3 : 4'h0, 16'd3, 1'b0);
            poll(v, 1'b0);
        end

        // Counter wrap: preload 0xFFFF on instance A, then a two-button press.
        force dut_a.press_count = 16'hFFFF;
        @(negedge clk);
        release dut_a.press_count;
        for (int i = 0; i < 4; i++) begin
            v = mk(4'hC, (i == 3) ? 4'h3 : 4'h0, (i == 3) ? 4'h3 : 4'h0, 4'h0, 16'd0, (i == 3));
            v.cnt_a = (i == 3) ? 16'h0001 : 16'hFFFF;
            v.cnt_b = (i == 3) ? 16'd5 : 16'd3;
            poll(v, i == 3);
        end

        rd_seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (avm_read_a === 1'b1 || avm_read_b === 1'b1) rd_seen++;
        end
        check("no_read_disabled", rd_seen, 0);
        enable = 1'b1;
        wait_read(n);
        check("reenable_delay", n, PI);

        // Reset while instance B sits in WAIT.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_read_b", avm_read_b, 0);
        check("midrst_state_a", btn_state_a, 0);
        check("midrst_count_a", press_count_a, 0);
        check("midrst_count_b", press_count_b, 0);
        check("midrst_irq_a", irq_a, 0);
        check("midrst_irq_b", irq_b, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_read(n);
        check("postrst_read_delay", n, PI);
        check("postrst_read_b", avm_read_b, 1);
        poll(mk(4'hC, 4'h0, 4'h0, 4'h0, 16'd0, 1'b0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
